// File: rtl/network_acc_pkg.sv
// Shared constants and result record for the accumulate/requantize block.
// Widths follow a Q8.8 x Q1.14 product stream requantized back to Q8.8.
package network_acc_pkg;

  localparam int PROD_WIDTH = 30;
  localparam int ACC_WIDTH  = 40;
  localparam int OUT_WIDTH  = 16;
  localparam int SHIFT      = 14;
  localparam int MAX_TERMS  = 1024;
  localparam int CNT_WIDTH  = 11;

  // Rounding and clip limits live one bit wider than the accumulator so the
  // rounding add cannot wrap.
  localparam logic signed [ACC_WIDTH:0] ROUND_HALF = (ACC_WIDTH+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX    = (ACC_WIDTH+1)'(32767);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN    = -(ACC_WIDTH+1)'(32768);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_TERMS - 1);

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] data;
    logic                        sat;
    logic                        ovf;
  } result_t;

endpackage

// File: rtl/network_acc_round.sv
// Combinational round-half-up, arithmetic shift and saturate to Q8.8.
// Optional ReLU on the clipped value when NETWORK_ACC_RELU_EN is defined.
module network_acc_round
  import network_acc_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] sum_in,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        sat_out
);

  logic signed [ACC_WIDTH:0] sum_ext;
  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum_ext = {sum_in[ACC_WIDTH-1], sum_in};
    rounded = sum_ext + ROUND_HALF;
    shifted = rounded >>> SHIFT;
    q_out   = shifted[OUT_WIDTH-1:0];
    sat_out = 1'b0;
    if (shifted > SAT_MAX) begin
      q_out   = SAT_MAX[OUT_WIDTH-1:0];
      sat_out = 1'b1;
    end else if (shifted < SAT_MIN) begin
      q_out   = SAT_MIN[OUT_WIDTH-1:0];
      sat_out = 1'b1;
    end
`ifdef NETWORK_ACC_RELU_EN
    if (q_out[OUT_WIDTH-1]) q_out = '0;
`endif
  end

endmodule

// File: rtl/network_acc_requant.sv
// Accumulates a signed product stream per dot product, then rounds, shifts and
// saturates to Q8.8; valid/ready both sides. Optional macro: NETWORK_ACC_RELU_EN.
module network_acc_requant
  import network_acc_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         out_ovf
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] r_q, r_d;
  logic                        r_valid_q, r_valid_d;
  logic                        r_ovf_q, r_ovf_d;
  result_t                     out_q, out_d;
  logic                        out_valid_q, out_valid_d;

  logic                        in_fire, out_fire, load_out;
  logic signed [OUT_WIDTH-1:0] round_q;
  logic                        round_sat;

  network_acc_round u_round (
    .sum_in  (r_q),
    .q_out   (round_q),
    .sat_out (round_sat)
  );

  // R may only refill when it is empty or drains into the out register this cycle.
  assign in_ready  = !(r_valid_q && out_valid_q && !out_ready);
  assign in_fire   = ce && in_valid && in_ready;
  assign out_fire  = ce && out_valid_q && out_ready;
  assign load_out  = ce && r_valid_q && (!out_valid_q || out_ready);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    r_valid_d   = r_valid_q;
    r_ovf_d     = r_ovf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    acc_next    = acc_q + {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};

    if (load_out) begin
      out_d       = '{data: round_q, sat: round_sat, ovf: r_ovf_q};
      out_valid_d = 1'b1;
      r_valid_d   = 1'b0;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (in_last || cnt_q == CNT_LAST) begin
        r_d       = acc_next;
        r_valid_d = 1'b1;
        r_ovf_d   = !in_last;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      r_q         <= '0;
      r_valid_q   <= 1'b0;
      r_ovf_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      r_valid_q   <= r_valid_d;
      r_ovf_q     <= r_ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_sat   = out_q.sat;
  assign out_ovf   = out_q.ovf;

endmodule

// File: tb/tb_network_acc_requant.sv
// Directed bench for network_acc_requant: rounding, saturation, forced end,
// back-pressure, clock enable and mid-stream reset.
module tb_network_acc_requant;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [29:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               out_ovf;

  int errors = 0;
  int checks = 0;

  network_acc_requant dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic signed [29:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, and let it drain (out_ready=1).
  task automatic expect_result(input string name, input logic signed [15:0] d,
                               input logic s, input logic o);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_sat !== s || out_ovf !== o) begin
      errors++;
      $display("FAIL %s: valid=%0b data=%0d sat=%0b ovf=%0b required valid=1 data=%0d sat=%0b ovf=%0b",
               name, out_valid, out_data, out_sat, out_ovf, d, s, o);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'sd0 ||
        out_sat !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b valid=%0b data=%0d sat=%0b ovf=%0b required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_sat, out_ovf);
    end
  endtask

  task automatic test_latency();
    send_beat(30'sd16384, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%0b required 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd1 || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: valid=%0b data=%0d sat=%0b required valid=1 data=1 sat=0",
               out_valid, out_data, out_sat);
    end
    step();
  endtask

  task automatic test_rounding();
    logic signed [29:0] vin  [3] = '{30'sd8192, -30'sd8192, -30'sd8193};
    logic signed [15:0] vexp [3] = '{16'sd1, 16'sd0, -16'sd1};
    for (int i = 0; i < 3; i++) begin
      send_beat(vin[i], 1'b1);
      expect_result($sformatf("round_%0d", vin[i]), vexp[i], 1'b0, 1'b0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send_beat(30'sd268435456, i == 3);
    expect_result("sat_pos", 16'sd32767, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(-30'sd268435456, i == 3);
`ifdef NETWORK_ACC_RELU_EN
    expect_result("sat_neg_relu", 16'sd0, 1'b1, 1'b0);
`else
    expect_result("sat_neg", -16'sd32768, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_max_terms();
    for (int i = 0; i < 1024; i++) send_beat(30'sd16384, 1'b0);
    expect_result("forced_end", 16'sd1024, 1'b0, 1'b1);
    send_beat(30'sd16384, 1'b1);
    expect_result("fresh_after_forced", 16'sd1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = 30'sd16384;
    step();
    in_data = 30'sd32768;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept2: in_ready=%0b required 1", in_ready);
    end
    step();
    in_data = 30'sd49152;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'sd1) begin
      errors++;
      $display("FAIL b2b_stall: in_ready=%0b valid=%0b data=%0d required 0 1 1",
               in_ready, out_valid, out_data);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 16'sd1) begin
      errors++;
      $display("FAIL b2b_hold: in_ready=%0b data=%0d required 0 1", in_ready, out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd2) begin
      errors++;
      $display("FAIL b2b_second: valid=%0b data=%0d required 1 2", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd3) begin
      errors++;
      $display("FAIL b2b_third: valid=%0b data=%0d required 1 3", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_ce();
    ce       = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 30'sd16384;
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ce_freeze: valid=%0b required 0", out_valid);
    end
    ce = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("ce_resume", 16'sd1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) send_beat(30'sd16384, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_beat(30'sd16384, 1'b0);
    send_beat(30'sd16384, 1'b1);
    expect_result("reset_discard", 16'sd2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_max_terms();
    test_back_to_back();
    test_ce();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
